// File: rtl/matrix_size_store.sv
// rtl/matrix_size_store.sv - slot-based matrix store with per-size lookup and read bursts
module matrix_size_store #(
  parameter int ELEM_W              = 8,
  parameter int NUM_SLOTS           = 8,
  parameter int MAX_MATRIX_PER_SIZE = 2,
  parameter int SEL_IDX_W           = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_start,
  input  logic [2:0]           wr_row,
  input  logic [2:0]           wr_col,
  input  logic                 wr_valid,
  input  logic [ELEM_W-1:0]    wr_data,
  output logic                 wr_ready,
  output logic                 store_done,
  output logic                 store_err,
  input  logic                 store_clr,
  input  logic                 sel_by_size,
  input  logic [2:0]           sel_row,
  input  logic [2:0]           sel_col,
  input  logic [SEL_IDX_W-1:0] sel_idx,
  output logic [SEL_IDX_W-1:0] size_cnt_out,
  input  logic                 matrix_burst_en,
  output logic                 elem_we,
  output logic [4:0]           elem_addr,
  output logic [ELEM_W-1:0]    elem_data,
  output logic                 buf_full,
  output logic                 burst_err,
  output logic                 rd_busy,
  output logic                 wr_busy
);

  localparam int SLOT_ELEMS = 25;
  localparam int DEPTH      = NUM_SLOTS * SLOT_ELEMS;
  localparam int AW         = $clog2(DEPTH);
  localparam int SW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_COMMIT} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FIND, R_READ, R_DONE} r_state_t;

  // Element storage: contents survive clears, only slot_valid gates access
  logic [ELEM_W-1:0]    mem [DEPTH];
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [2:0]           slot_row [NUM_SLOTS];
  logic [2:0]           slot_col [NUM_SLOTS];

  // Write side
  w_state_t      w_state;
  logic [SW-1:0] w_slot;
  logic [4:0]    w_cnt;
  logic [4:0]    w_n;
  logic [AW-1:0] w_addr;

  // Read side
  r_state_t              r_state;
  logic [2:0]            r_row;
  logic [2:0]            r_col;
  logic [SEL_IDX_W-1:0]  r_idx;
  logic [SW-1:0]         r_slot;
  logic [4:0]            r_cnt;
  logic [4:0]            r_n;
  logic [AW-1:0]         r_addr;

  // Lookup results
  logic          free_any;
  logic [SW-1:0] free_slot;
  int            wr_size_cnt;
  int            sel_size_cnt;
  int            seen;
  logic          find_hit;
  logic [SW-1:0] find_slot;
  logic          wr_dims_ok;
  logic          wr_accept;

  assign w_addr = AW'(int'(w_slot) * SLOT_ELEMS + int'(w_cnt));
  assign r_addr = AW'(int'(r_slot) * SLOT_ELEMS + int'(r_cnt));

  assign wr_dims_ok = (wr_row != 3'd0) && (wr_row <= 3'd5) &&
                      (wr_col != 3'd0) && (wr_col <= 3'd5);
  assign wr_accept  = wr_dims_ok && free_any && (wr_size_cnt < MAX_MATRIX_PER_SIZE);

  assign size_cnt_out = sel_by_size ? SEL_IDX_W'(sel_size_cnt) : '0;
  assign wr_ready     = (w_state == W_FILL);
  assign wr_busy      = (w_state != W_IDLE);
  assign rd_busy      = (r_state != R_IDLE);

  // Lowest free slot, size counts, and the in-order search over registered valid bits
  always_comb begin
    free_any     = 1'b0;
    free_slot    = '0;
    wr_size_cnt  = 0;
    sel_size_cnt = 0;
    seen         = 0;
    find_hit     = 1'b0;
    find_slot    = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!slot_valid[s]) begin
        free_any  = 1'b1;
        free_slot = SW'(s);
      end
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slot_valid[s] && slot_row[s] == wr_row && slot_col[s] == wr_col)
        wr_size_cnt = wr_size_cnt + 1;
      if (slot_valid[s] && slot_row[s] == sel_row && slot_col[s] == sel_col)
        sel_size_cnt = sel_size_cnt + 1;
      if (slot_valid[s] && slot_row[s] == r_row && slot_col[s] == r_col) begin
        if (!find_hit && seen == int'(r_idx)) begin
          find_hit  = 1'b1;
          find_slot = SW'(s);
        end
        seen = seen + 1;
      end
    end
  end

  // Element writes into the slot being filled
  always_ff @(posedge clk) begin
    if (!rst && !store_clr && w_state == W_FILL && wr_valid)
      mem[w_addr] <= wr_data;
  end

  // Slot dimensions recorded at allocation; the slot stays invalid until commit
  always_ff @(posedge clk) begin
    if (!rst && !store_clr && w_state == W_IDLE && wr_start && wr_accept) begin
      slot_row[free_slot] <= wr_row;
      slot_col[free_slot] <= wr_col;
    end
  end

  // Write FSM: admission check, element fill, commit of the valid bit
  always_ff @(posedge clk) begin
    if (rst || store_clr) begin
      w_state    <= W_IDLE;
      slot_valid <= '0;
      w_slot     <= '0;
      w_cnt      <= '0;
      w_n        <= '0;
      store_done <= 1'b0;
      store_err  <= 1'b0;
    end else begin
      store_done <= 1'b0;
      store_err  <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (wr_start) begin
            if (wr_accept) begin
              w_slot  <= free_slot;
              w_cnt   <= '0;
              w_n     <= 5'({2'b00, wr_row} * {2'b00, wr_col});
              w_state <= W_FILL;
            end else begin
              store_err <= 1'b1;
            end
          end
        end
        W_FILL: begin
          if (wr_valid) begin
            w_cnt <= w_cnt + 5'd1;
            if (w_cnt == w_n - 5'd1)
              w_state <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          slot_valid[w_slot] <= 1'b1;
          store_done         <= 1'b1;
          w_state            <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: latch query, single-cycle search, streamed read with 1-cycle memory latency
  always_ff @(posedge clk) begin
    if (rst || store_clr) begin
      r_state   <= R_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_idx     <= '0;
      r_slot    <= '0;
      r_cnt     <= '0;
      r_n       <= '0;
      elem_we   <= 1'b0;
      elem_addr <= '0;
      elem_data <= '0;
      buf_full  <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      elem_we   <= 1'b0;
      burst_err <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (matrix_burst_en) begin
            r_row    <= sel_row;
            r_col    <= sel_col;
            r_idx    <= sel_idx;
            r_n      <= 5'({2'b00, sel_row} * {2'b00, sel_col});
            buf_full <= 1'b0;
            r_state  <= R_FIND;
          end
        end
        R_FIND: begin
          if (sel_by_size && find_hit) begin
            r_slot  <= find_slot;
            r_cnt   <= '0;
            r_state <= R_READ;
          end else begin
            burst_err <= 1'b1;
            r_state   <= R_DONE;
          end
        end
        R_READ: begin
          elem_we   <= 1'b1;
          elem_addr <= r_cnt;
          elem_data <= mem[r_addr];
          r_cnt     <= r_cnt + 5'd1;
          if (r_cnt == r_n - 5'd1)
            r_state <= R_DONE;
        end
        R_DONE: begin
          buf_full <= 1'b1;
          r_state  <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_size_store.sv
// tb/tb_matrix_size_store.sv - self-checking bench for matrix_size_store
module tb_matrix_size_store;

  logic       clk;
  logic       rst;
  logic       wr_start;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       store_done;
  logic       store_err;
  logic       store_clr;
  logic       sel_by_size;
  logic [2:0] sel_row;
  logic [2:0] sel_col;
  logic [1:0] sel_idx;
  logic [1:0] size_cnt_out;
  logic       matrix_burst_en;
  logic       elem_we;
  logic [4:0] elem_addr;
  logic [7:0] elem_data;
  logic       buf_full;
  logic       burst_err;
  logic       rd_busy;
  logic       wr_busy;

  matrix_size_store dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_row(wr_row), .wr_col(wr_col),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .store_done(store_done), .store_err(store_err), .store_clr(store_clr),
    .sel_by_size(sel_by_size), .sel_row(sel_row), .sel_col(sel_col), .sel_idx(sel_idx),
    .size_cnt_out(size_cnt_out), .matrix_burst_en(matrix_burst_en),
    .elem_we(elem_we), .elem_addr(elem_addr), .elem_data(elem_data),
    .buf_full(buf_full), .burst_err(burst_err), .rd_busy(rd_busy), .wr_busy(wr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] base;
    bit         exp_err;
    int         exp_cnt;
  } wr_vec_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } elem_t;

  wr_vec_t vecs [13];
  elem_t   exp_q [$];
  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  int first_we = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  // Advance one cycle and score any element the DUT writes out
  task automatic tick();
    elem_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (elem_we) begin
      we_cnt++;
      if (we_cnt == 1) first_we = cyc;
      if (exp_q.size() == 0) begin
        chk("elem_we_unexpected", elem_we, 0);
      end else begin
        e = exp_q.pop_front();
        chk("elem_addr", elem_addr, e.addr);
        chk("elem_data", elem_data, e.data);
      end
    end
  endtask

  task automatic wr_mat(input logic [2:0] r, input logic [2:0] c, input logic [7:0] base,
                        input bit exp_err, input bit stall);
    int n;
    int k;
    n = int'(r) * int'(c);
    wr_row = r; wr_col = c; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    if (exp_err) begin
      chk("store_err", store_err, 1);
      chk("wr_busy_rej", wr_busy, 0);
      chk("wr_ready_rej", wr_ready, 0);
      return;
    end
    chk("store_err_ok", store_err, 0);
    chk("wr_ready", wr_ready, 1);
    for (int i = 0; i < n; i++) begin
      if (stall && i == 1) begin
        wr_valid = 1'b0; wr_start = 1'b1; wr_row = 3'd1; wr_col = 3'd1;
        tick();
        wr_start = 1'b0;
      end
      wr_valid = 1'b1; wr_data = base + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    k = 0;
    while (!store_done && k < 5) begin
      tick();
      k++;
    end
    chk("store_done", store_done, 1);
  endtask

  task automatic burst(input logic [2:0] r, input logic [2:0] c, input logic [1:0] idx,
                       input bit hit, input logic [7:0] base);
    int n;
    int t0;
    elem_t e;
    n = hit ? int'(r) * int'(c) : 0;
    for (int i = 0; i < n; i++) begin
      e.addr = 5'(i);
      e.data = base + 8'(i);
      exp_q.push_back(e);
    end
    sel_row = r; sel_col = c; sel_idx = idx;
    we_cnt = 0; first_we = 0; t0 = cyc;
    matrix_burst_en = 1'b1;
    tick();
    matrix_burst_en = 1'b0;
    chk("buf_full_drop", buf_full, 0);
    chk("rd_busy", rd_busy, 1);
    tick();
    chk("burst_err", burst_err, !hit);
    if (!hit) begin
      tick();
      chk("buf_full_miss", buf_full, 1);
      chk("we_cnt_miss", we_cnt, 0);
    end else begin
      for (int i = 0; i < n; i++) tick();
      chk("buf_full_early", buf_full, 0);
      tick();
      chk("buf_full", buf_full, 1);
      chk("we_cnt", we_cnt, n);
      chk("first_we_lat", first_we - t0, 3);
      chk("q_empty", exp_q.size(), 0);
    end
    chk("rd_busy_end", rd_busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd2, 3'd3, 8'd1,   1'b0, 1};
    vecs[1]  = '{3'd2, 3'd2, 8'd10,  1'b0, 1};
    vecs[2]  = '{3'd2, 3'd2, 8'd20,  1'b0, 2};
    vecs[3]  = '{3'd2, 3'd2, 8'd30,  1'b1, 2};
    vecs[4]  = '{3'd0, 3'd2, 8'd0,   1'b1, 0};
    vecs[5]  = '{3'd1, 3'd6, 8'd0,   1'b1, 0};
    vecs[6]  = '{3'd6, 3'd1, 8'd0,   1'b1, 0};
    vecs[7]  = '{3'd1, 3'd1, 8'd40,  1'b0, 1};
    vecs[8]  = '{3'd5, 3'd5, 8'd50,  1'b0, 1};
    vecs[9]  = '{3'd3, 3'd1, 8'd80,  1'b0, 1};
    vecs[10] = '{3'd1, 3'd2, 8'd90,  1'b0, 1};
    vecs[11] = '{3'd4, 3'd1, 8'd100, 1'b0, 1};
    vecs[12] = '{3'd1, 3'd1, 8'd0,   1'b1, 1};

    rst = 1'b1; wr_start = 1'b0; wr_row = '0; wr_col = '0; wr_valid = 1'b0; wr_data = '0;
    store_clr = 1'b0; sel_by_size = 1'b1; sel_row = 3'd2; sel_col = 3'd3; sel_idx = '0;
    matrix_burst_en = 1'b0;
    tick(); tick();
    chk("rst_store_done", store_done, 0);
    chk("rst_store_err", store_err, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_burst_err", burst_err, 0);
    chk("rst_elem_we", elem_we, 0);
    chk("rst_elem_data", elem_data, 0);
    chk("rst_size_cnt", size_cnt_out, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      wr_mat(vecs[i].row, vecs[i].col, vecs[i].base, vecs[i].exp_err, i == 0);
      sel_row = vecs[i].row; sel_col = vecs[i].col;
      #1;
      chk($sformatf("size_cnt_v%0d", i), size_cnt_out, vecs[i].exp_cnt);
      tick();
    end

    burst(3'd2, 3'd3, 2'd0, 1'b1, 8'd1);
    burst(3'd2, 3'd2, 2'd1, 1'b1, 8'd20);
    burst(3'd2, 3'd2, 2'd0, 1'b1, 8'd10);
    burst(3'd1, 3'd1, 2'd3, 1'b0, 8'd0);
    burst(3'd2, 3'd2, 2'd2, 1'b0, 8'd0);
    burst(3'd5, 3'd1, 2'd0, 1'b0, 8'd0);

    sel_by_size = 1'b0; sel_row = 3'd2; sel_col = 3'd3;
    #1;
    chk("size_cnt_disabled", size_cnt_out, 0);
    burst(3'd2, 3'd3, 2'd0, 1'b0, 8'd0);
    sel_by_size = 1'b1;

    // store_clr in the middle of a 5x5 burst
    for (int i = 0; i < 25; i++) exp_q.push_back('{5'(i), 8'd50 + 8'(i)});
    sel_row = 3'd5; sel_col = 3'd5; sel_idx = 2'd0; we_cnt = 0;
    matrix_burst_en = 1'b1;
    tick();
    matrix_burst_en = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    store_clr = 1'b1;
    tick();
    store_clr = 1'b0;
    chk("clr_elem_we", elem_we, 0);
    chk("clr_buf_full", buf_full, 0);
    chk("clr_rd_busy", rd_busy, 0);
    chk("clr_we_cnt", we_cnt, 10);
    exp_q.delete();
    #1;
    chk("clr_cnt_5x5", size_cnt_out, 0);
    sel_row = 3'd2; sel_col = 3'd2;
    #1;
    chk("clr_cnt_2x2", size_cnt_out, 0);
    tick();
    chk("clr_no_elem_we", elem_we, 0);

    // rst in the middle of a write after 3 of 4 elements
    wr_mat(3'd1, 3'd1, 8'd7, 1'b0, 1'b0);
    sel_row = 3'd1; sel_col = 3'd1;
    #1;
    chk("pre_rst_cnt_1x1", size_cnt_out, 1);
    wr_row = 3'd2; wr_col = 3'd2; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'd60 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("pre_rst_wr_busy", wr_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_wr_busy", wr_busy, 0);
    chk("rst_mid_wr_ready", wr_ready, 0);
    chk("rst_mid_cnt_1x1", size_cnt_out, 0);
    sel_row = 3'd2; sel_col = 3'd2;
    #1;
    chk("rst_mid_cnt_2x2", size_cnt_out, 0);
    tick();
    wr_mat(3'd2, 3'd2, 8'd70, 1'b0, 1'b0);
    tick();
    burst(3'd2, 3'd2, 2'd0, 1'b1, 8'd70);
    burst(3'd1, 3'd1, 2'd0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_size_store.md
MATRIX_SIZE_STORE -- requirements
Module: matrix_size_store

Interface
REQ-001 Parameter ELEM_W, default 8: element width in bits.
REQ-002 Parameter NUM_SLOTS, default 8: matrix slots; each slot holds up to 25 elements.
REQ-003 Parameter MAX_MATRIX_PER_SIZE, default 2: maximum stored matrices per (row,col) size.
REQ-004 Parameter SEL_IDX_W, default 2: width of per-size index and count.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 wr_start  in  1  one-cycle pulse that opens a new matrix write.
REQ-008 wr_row, wr_col  in  3 each  dimensions of the new matrix; legal range 1..5.
REQ-009 wr_valid / wr_data  in  1 / ELEM_W  element strobe and data, row-major order.
REQ-010 wr_ready  out  1  high while an element is accepted this cycle.
REQ-011 store_done / store_err  out  1 each  one-cycle pulse: matrix committed / matrix rejected.
REQ-012 store_clr  in  1  clears all slots.
REQ-013 sel_by_size  in  1  enables size-based lookup; when low, size_cnt_out=0 and bursts return burst_err.
REQ-014 sel_row, sel_col  in  3 each  queried size.
REQ-015 sel_idx  in  SEL_IDX_W  index among matrices of the queried size.
REQ-016 size_cnt_out  out  SEL_IDX_W  count of valid slots matching sel_row/sel_col; combinational.
REQ-017 matrix_burst_en  in  1  one-cycle pulse that starts a read burst.
REQ-018 elem_we / elem_addr / elem_data  out  1 / 5 / ELEM_W  buffer write strobe, element index 0..N-1, data.
REQ-019 buf_full  out  1  level signal: the burst is complete.
REQ-020 burst_err  out  1  one-cycle pulse: sel_idx has no matching matrix.
REQ-021 rd_busy, wr_busy  out  1 each  the read or write FSM is not idle.

Function
REQ-022 Storage: slot s uses element addresses s*25 .. s*25+24; the memory has a 1-cycle read latency. Each slot holds a valid bit plus row and col.
REQ-023 Write FSM states: W_IDLE, W_FILL, W_COMMIT. A wr_start pulse is considered only in W_IDLE.
REQ-024 On wr_start, the store rejects the matrix if any of these holds: a dimension is 0 or greater than 5; no slot is free; or the count for that size already equals MAX_MATRIX_PER_SIZE.
REQ-025 On rejection, store_err pulses on the next cycle and the FSM stays in W_IDLE; no elements are accepted.
REQ-026 Otherwise the store allocates the lowest free slot and enters W_FILL.
REQ-027 In W_FILL, wr_ready=1. Each cycle with wr_valid=1 stores one element. After N=row*col elements, the FSM enters W_COMMIT.
REQ-028 In W_COMMIT, the slot valid bit is set, store_done pulses, and the FSM returns to W_IDLE.
REQ-029 In W_FILL, wr_valid=0 stalls the write with no timeout. wr_start in W_FILL is ignored.
REQ-030 Per-size ordering: index k selects the (k+1)-th valid matching slot in ascending slot number.
REQ-031 Read FSM states: R_IDLE, R_FIND, R_READ, R_DONE.
REQ-032 When matrix_burst_en arrives at cycle T in R_IDLE, the block latches sel_row, sel_col and sel_idx, drops buf_full, and is in R_FIND at T+1.
REQ-033 R_FIND performs a single-cycle priority search. On a hit the FSM goes to R_READ. On a miss, or with sel_by_size=0, the FSM goes to R_DONE and burst_err pulses.
REQ-034 R_READ issues one address per cycle. elem_we is high from T+3 through T+2+N, with elem_addr counting 0..N-1.
REQ-035 buf_full=1 from T+3+N, or from T+3 after a miss. It is held until the next accepted matrix_burst_en, store_clr or rst. R_DONE returns to R_IDLE.
REQ-036 matrix_burst_en is ignored unless the read FSM is in R_IDLE.
REQ-037 Simultaneous commit and burst: the R_FIND search uses the valid bits as registered at the start of the R_FIND cycle. A commit in that same cycle is not visible to the search.
REQ-038 The read and write FSMs run independently. A write never targets a valid slot, so a write cannot overlap a slot being read.
REQ-039 store_clr, when rst=0, acts on the next edge: all valid bits clear, both FSMs go idle, buf_full=0, and no pulses are emitted. In-progress bursts and writes are abandoned.
REQ-040 Memory contents are not cleared; only the valid bits gate access.

Reset
REQ-041 On rst=1 at a clock edge, all valid bits clear and both FSMs go idle. All outputs go to 0, with size_cnt_out=0 as it is combinational.
REQ-042 rst has priority over store_clr and over all other inputs, including in the middle of an operation.

Verification
REQ-043 Write a 2x3 matrix with data 1..6, then burst with sel 2x3 idx0 -> elem_we for 6 cycles, addr 0..5, data 1..6, first at T+3; buf_full=1 at T+9.
REQ-044 Write three 2x2 matrices -> the third gets store_err; size_cnt_out(2x2)=2; idx1 returns the second matrix's data.
REQ-045 Burst with idx=3 for a size holding one matrix -> burst_err at T+2, no elem_we, buf_full=1 at T+3.
REQ-046 wr_start with row=0 or col=6 -> store_err, wr_busy stays 0; with all 8 slots valid, a legal 1x1 -> store_err.
REQ-047 Assert store_clr midway through a 5x5 burst -> elem_we stops next cycle, buf_full=0, all counts 0.
REQ-048 Assert rst at mid-write after 3 of 4 elements -> next cycle wr_busy=0 and size_cnt_out=0; a re-write then succeeds into slot 0.
